alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 24-bit ripple ALU (chain of 1-bit slices).

---
 rtl/alu_result_stage_if.sv | 48 ++++
 rtl/alu_result_stage.sv | 152 +++++++++++++++
 tb/tb_alu_result_stage.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// ============================================================================
//  Module      : alu_result_stage_if
//  Description : Handshake/bus bundle between the ripple ALU, the registered
//                result stage and the writeback consumer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_result_stage_if #(
    parameter int WIDTH = 24
);
    // Producer (ALU) side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic [1:0]       operation;
    logic             binvert;
    logic             a_msb;
    logic             b_msb;

    // Consumer (writeback) side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_v;

    // The result stage itself
    modport slave (
        input  in_valid, result, cout, operation, binvert, a_msb, b_msb,
        output in_ready,
        output out_valid, out_result, out_z, out_n, out_c, out_v,
        input  out_ready
    );

    // The environment around the stage (ALU plus writeback)
    modport master (
        output in_valid, result, cout, operation, binvert, a_msb, b_msb,
        input  in_ready,
        input  out_valid, out_result, out_z, out_n, out_c, out_v,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
//  Module      : alu_result_stage
//  Description : Registered ALU output stage. Derives Z/N/C/V from the ALU
//                result, stores them with the result in a 2-entry skid buffer
//                and hands them to writeback over valid/ready. in_ready comes
//                straight from a flop, so there is no comb path from
//                out_ready back to the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter int WIDTH = 24
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_result_stage_if.slave bus
);

    localparam logic [1:0] c_OP_ADD = 2'b10;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
    } entry_t;

    state_t state_q;
    state_t state_d;
    entry_t main_q;
    entry_t skid_q;
    logic   in_ready_q;
    logic   in_ready_d;
    logic   out_valid_q;
    logic   out_valid_d;

    logic   w_push;
    logic   w_pop;
    logic   w_load_main_in;
    logic   w_load_main_skid;
    logic   w_load_skid;
    entry_t w_in_entry;

    logic   w_is_add;
    logic   w_mb;
    logic   w_r;

    assign w_push = bus.in_valid & in_ready_q;
    assign w_pop  = out_valid_q & bus.out_ready;

    // Flag derivation for the incoming ALU result; carry and overflow only
    // mean something for ADD, so they are forced low for logic ops.
    assign w_is_add = (bus.operation == c_OP_ADD);
    assign w_mb     = bus.b_msb ^ bus.binvert;
    assign w_r      = bus.result[WIDTH-1];

    always_comb begin
        w_in_entry        = '0;
        w_in_entry.result = bus.result;
        w_in_entry.z      = (bus.result == '0);
        w_in_entry.n      = w_r;
        w_in_entry.c      = w_is_add & bus.cout;
        w_in_entry.v      = w_is_add & (bus.a_msb ^ w_r) & (w_mb ^ w_r);
    end

    // Next-state, storage steering and registered handshake targets
    always_comb begin
        state_d          = state_q;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (w_push) begin
                    state_d        = S_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_push) begin
                    state_d     = S_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_pop) begin
                    state_d          = S_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        in_ready_d  = (state_d != S_TWO);
        out_valid_d = (state_d != S_EMPTY);
    end

    // State and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Entry storage; only written on an accepted push or skid promotion, so
    // junk on the inputs while in_valid is low never reaches held entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (w_load_main_in) begin
                main_q <= w_in_entry;
            end else if (w_load_main_skid) begin
                main_q <= skid_q;
            end
            if (w_load_skid) begin
                skid_q <= w_in_entry;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = main_q.result;
    assign bus.out_z      = main_q.z;
    assign bus.out_n      = main_q.n;
    assign bus.out_c      = main_q.c;
    assign bus.out_v      = main_q.v;

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Self-checking bench for alu_result_stage. The ALU result is
//                produced here from operands with plain arithmetic, and a
//                queue of expected entries tracks what writeback should see.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

    localparam int c_W = 24;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    // Expected entries in FIFO order: {result, z, n, c, v}
    logic [c_W+3:0] exp_q[$];
    logic [c_W+3:0] cur_exp;
    logic           last_push;

    alu_result_stage_if #(.WIDTH(c_W)) bus ();

    alu_result_stage #(.WIDTH(c_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_signed24(input logic [c_W-1:0] x);
        return x[c_W-1] ? int'(x) - (1 << c_W) : int'(x);
    endfunction

    // Act as the ALU: compute the result from operands and drive the bus,
    // remembering what writeback should receive for this operation.
    task automatic drive(input logic valid, input logic [1:0] op, input logic binv,
                         input logic [c_W-1:0] a, input logic [c_W-1:0] b);
        logic [c_W-1:0] r;
        logic           co;
        logic [c_W:0]   sum;
        int             t;
        logic           c_flag;
        logic           v_flag;
        co     = 1'($urandom);
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op)
            2'b00: r = a & b;
            2'b01: r = a | b;
            2'b11: r = a ^ b;
            default: begin
                sum    = {1'b0, a} + {1'b0, (binv ? ~b : b)} + {{c_W{1'b0}}, binv};
                r      = sum[c_W-1:0];
                co     = sum[c_W];
                c_flag = co;
                t      = binv ? to_signed24(a) - to_signed24(b) : to_signed24(a) + to_signed24(b);
                v_flag = (t > (1 << (c_W-1)) - 1) || (t < -(1 << (c_W-1)));
            end
        endcase
        if (valid) begin
            bus.result = r;
            bus.cout   = co;
        end else begin
            bus.result = c_W'($urandom);
            bus.cout   = 1'($urandom);
        end
        bus.in_valid  = valid;
        bus.operation = op;
        bus.binvert   = binv;
        bus.a_msb     = a[c_W-1];
        bus.b_msb     = b[c_W-1];
        cur_exp       = {r, (r == '0), r[c_W-1], c_flag, v_flag};
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'($urandom), 1'($urandom), c_W'($urandom), c_W'($urandom));
    endtask

    // One clock: compare outputs mid-cycle against the queue, then apply
    // the handshakes that happen at the next rising edge.
    task automatic cycle();
        logic push;
        logic pop;
        @(negedge clk);
        check_value("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
        check_value("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() > 0)
            check_value("entry", 64'({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v}),
                        64'(exp_q[0]));
        push = bus.in_valid && (exp_q.size() < 2);
        pop  = (exp_q.size() > 0) && bus.out_ready;
        @(posedge clk);
        #1;
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(cur_exp);
        last_push = push;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        last_push     = 1'b0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive_idle();

        // Reset state
        #12;
        check_value("rst_valid", 64'(bus.out_valid), 64'd0);
        check_value("rst_ready", 64'(bus.in_ready), 64'd1);
        check_value("rst_result", 64'(bus.out_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD 0x7FFFFF + 1 -> signed overflow into negative
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 24'h7FFFFF, 24'h000001);
        cycle();
        check_value("add_res", 64'(bus.out_result), 64'h800000);
        check_value("add_flags", 64'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 64'b0101);

        // SUB 5 - 5 -> zero with carry
        drive(1'b1, 2'b10, 1'b1, 24'h000005, 24'h000005);
        cycle();
        check_value("sub_res", 64'(bus.out_result), 64'h000000);
        check_value("sub_flags", 64'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 64'b1010);

        // AND with a live carry-out: C and V must stay low
        drive(1'b1, 2'b00, 1'b0, 24'hFFFFFF, 24'hFFFFFF);
        bus.cout = 1'b1;
        cycle();
        check_value("and_res", 64'(bus.out_result), 64'hFFFFFF);
        check_value("and_flags", 64'({bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 64'b0100);
        drive_idle();
        cycle();

        // Backpressure: three pushes with writeback stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, 1'b0, 24'h000001, 24'h0);
        cycle();
        drive(1'b1, 2'b01, 1'b0, 24'h000002, 24'h0);
        cycle();
        check_value("bp_ready_low", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 2'b01, 1'b0, 24'h000003, 24'h0);
        cycle();
        cycle();
        check_value("bp_held", 64'(bus.out_result), 64'h000001);
        bus.out_ready = 1'b1;
        begin
            int k;
            k = 0;
            last_push = 1'b0;
            while (!last_push && k < 10) begin
                cycle();
                k++;
            end
            check_value("bp_accept3", 64'(last_push), 64'd1);
        end
        drive_idle();
        for (int i = 0; i < 4; i++) cycle();
        check_value("bp_drained", 64'(exp_q.size()), 64'd0);

        // Streaming: 100 back-to-back random ADD/SUB
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 2'b10, 1'($urandom), c_W'($urandom), c_W'($urandom));
            cycle();
            check_value("stream_ready", 64'(bus.in_ready), 64'd1);
        end
        drive_idle();
        cycle();

        // Mixed random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0)
                drive(1'b1, 2'($urandom), 1'($urandom), c_W'($urandom), c_W'($urandom));
            else
                drive_idle();
            cycle();
        end

        // Asynchronous reset while holding two entries
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 24'h7FFFFF, 24'h000001);
        cycle();
        drive(1'b1, 2'b11, 1'b0, 24'h123456, 24'h654321);
        cycle();
        check_value("two_ready", 64'(bus.in_ready), 64'd0);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_value("arst_valid", 64'(bus.out_valid), 64'd0);
        check_value("arst_ready", 64'(bus.in_ready), 64'd1);
        check_value("arst_out", 64'({bus.out_result, bus.out_z, bus.out_n, bus.out_c, bus.out_v}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b10, 1'b1, 24'h000003, 24'h000007);
        cycle();
        drive_idle();
        for (int i = 0; i < 3; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
